// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: EX-stage taken-branch/jump redirect sequencer with squash and taken counter
module branch_redirect_ctrl #(
   parameter int WIDTH        = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int COUNT_W      = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ex_valid,
   input  logic               stall_in,
   input  logic               ex_beq,
   input  logic               ex_bne,
   input  logic               ex_jump,
   input  logic               ex_zero,
   input  logic [WIDTH-1:0]   ex_br_target,
   input  logic [WIDTH-1:0]   ex_j_target,
   input  logic               redir_ready,
   output logic               redir_valid,
   output logic [WIDTH-1:0]   redir_pc,
   output logic               flush_ifid,
   output logic               flush_idex,
   output logic               busy,
   output logic [COUNT_W-1:0] taken_count
);
   localparam int CW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES + 1) : 1;
   typedef enum logic [1:0] {IDLE, REDIRECT, SQUASH} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic take;
   logic [WIDTH-1:0] target;
   assign take = state == IDLE && ex_valid && !stall_in &&
                 (ex_jump || (ex_beq ? ex_zero : ex_bne && !ex_zero));
   assign target = ex_jump ? ex_j_target : ex_br_target;
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE:     state_n = take ? REDIRECT : IDLE;
         REDIRECT: if (redir_ready) begin
            state_n = FLUSH_CYCLES > 0 ? SQUASH : IDLE;
            cnt_n   = CW'(FLUSH_CYCLES);
         end
         SQUASH: begin
            cnt_n   = cnt - 1'b1;
            state_n = cnt == CW'(1) ? IDLE : SQUASH;
         end
         default:  state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         redir_valid <= 1'b0;
         redir_pc    <= '0;
         flush_ifid  <= 1'b0;
         flush_idex  <= 1'b0;
         busy        <= 1'b0;
         taken_count <= '0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         redir_valid <= state_n == REDIRECT;
         flush_idex  <= state_n == REDIRECT;
         flush_ifid  <= state_n != IDLE;
         busy        <= state_n != IDLE;
         if (take) begin
            redir_pc <= target;
            if (~&taken_count) taken_count <= taken_count + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: randomized and directed check of two configurations against a spec-level model
module tb_branch_redirect_ctrl;
   logic clk = 1'b0;
   logic reset, ex_valid, stall_in, ex_beq, ex_bne, ex_jump, ex_zero, redir_ready;
   logic [31:0] ex_br_target, ex_j_target;
   logic a_rv, a_fi, a_fd, a_busy, b_rv, b_fi, b_fd, b_busy;
   logic [31:0] a_pc, b_pc;
   logic [15:0] a_tc;
   logic [1:0] b_tc;
   bit m_pend[2];
   int m_sq[2];
   logic [31:0] m_pc[2];
   int m_cnt[2];
   int fl[2] = '{2, 0};
   int cmax[2] = '{65535, 3};
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   branch_redirect_ctrl u_a (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .stall_in(stall_in), .ex_beq(ex_beq),
      .ex_bne(ex_bne), .ex_jump(ex_jump), .ex_zero(ex_zero), .ex_br_target(ex_br_target),
      .ex_j_target(ex_j_target), .redir_ready(redir_ready), .redir_valid(a_rv), .redir_pc(a_pc),
      .flush_ifid(a_fi), .flush_idex(a_fd), .busy(a_busy), .taken_count(a_tc));
   branch_redirect_ctrl #(.WIDTH(32), .FLUSH_CYCLES(0), .COUNT_W(2)) u_b (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .stall_in(stall_in), .ex_beq(ex_beq),
      .ex_bne(ex_bne), .ex_jump(ex_jump), .ex_zero(ex_zero), .ex_br_target(ex_br_target),
      .ex_j_target(ex_j_target), .redir_ready(redir_ready), .redir_valid(b_rv), .redir_pc(b_pc),
      .flush_ifid(b_fi), .flush_idex(b_fd), .busy(b_busy), .taken_count(b_tc));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic model_step();
      bit tk;
      logic [31:0] tg;
      tk = 1'b0;
      tg = ex_br_target;
      if (ex_jump) begin
         tk = 1'b1;
         tg = ex_j_target;
      end else if (ex_beq) tk = ex_zero;
      else if (ex_bne) tk = !ex_zero;
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_pend[k] = 1'b0;
            m_sq[k]   = 0;
            m_pc[k]   = '0;
            m_cnt[k]  = 0;
         end else if (m_pend[k]) begin
            if (redir_ready) begin
               m_pend[k] = 1'b0;
               m_sq[k]   = fl[k];
            end
         end else if (m_sq[k] > 0) m_sq[k]--;
         else if (ex_valid && !stall_in && tk) begin
            m_pend[k] = 1'b1;
            m_pc[k]   = tg;
            m_cnt[k]  = m_cnt[k] < cmax[k] ? m_cnt[k] + 1 : cmax[k];
         end
      end
   endtask
   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("redir_valid%0d", k), k ? b_rv : a_rv, m_pend[k]);
         chk($sformatf("redir_pc%0d", k), k ? b_pc : a_pc, m_pc[k]);
         chk($sformatf("flush_ifid%0d", k), k ? b_fi : a_fi, m_pend[k] || m_sq[k] > 0);
         chk($sformatf("flush_idex%0d", k), k ? b_fd : a_fd, m_pend[k]);
         chk($sformatf("busy%0d", k), k ? b_busy : a_busy, m_pend[k] || m_sq[k] > 0);
         chk($sformatf("taken_count%0d", k), k ? 32'(b_tc) : 32'(a_tc), m_cnt[k]);
      end
   endtask
   task automatic step();
      model_step();
      @(negedge clk);
      check_all();
   endtask
   task automatic set_in(input logic v, st, j, bq, bn, z, input logic [31:0] bt, jt, input logic rdy);
      ex_valid = v; stall_in = st; ex_jump = j; ex_beq = bq; ex_bne = bn; ex_zero = z;
      ex_br_target = bt; ex_j_target = jt; redir_ready = rdy;
   endtask
   task automatic idle(input int n);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
      repeat (n) step();
   endtask
   initial begin
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      step();
      reset = 1'b0;
      set_in(1, 0, 0, 1, 0, 1, 32'h40, 0, 1);
      step();
      idle(4);
      set_in(1, 0, 0, 0, 1, 1, 32'h80, 0, 1);
      step();
      set_in(1, 0, 0, 0, 1, 0, 32'h80, 0, 1);
      step();
      idle(4);
      set_in(1, 0, 1, 1, 0, 0, 32'h20, 32'h1000, 0);
      step();
      repeat (3) begin
         set_in(1, 0, 1, 0, 0, 0, $urandom, $urandom, 0);
         step();
      end
      redir_ready = 1'b1;
      step();
      idle(4);
      set_in(1, 1, 0, 1, 0, 1, 32'h44, 0, 1);
      repeat (2) step();
      stall_in = 1'b0;
      step();
      idle(4);
      set_in(1, 0, 1, 0, 0, 0, 0, 32'h200, 0);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      set_in(1, 0, 1, 0, 0, 0, 0, 32'h300, 1);
      step();
      idle(4);
      repeat (5) begin
         set_in(1, 0, 1, 0, 0, 0, 0, $urandom, 1);
         step();
         idle(3);
      end
      repeat (3000) begin
         reset = $urandom_range(0, 99) == 0;
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 1'($urandom),
                $urandom, $urandom, 1'($urandom));
         step();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- EX-stage control-flow sequencer for the MIPS pipeline.
- Consumes the EX branch-target adder result, the jump target and the ALU zero flag, and decides whether control flow is taken.
- On a taken decision it issues a held redirect to fetch with a valid/ready handshake, squashes wrong-path instructions in IF/ID and ID/EX, and counts taken redirects.

Parameters:
- WIDTH, 32, address width of targets and redirect PC.
- FLUSH_CYCLES, 2, number of IF/ID squash cycles after fetch accepts the redirect (0 legal).
- COUNT_W, 16, width of the saturating taken-redirect counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX stage holds a real (non-bubble) instruction.
- stall_in  in  1  hazard unit is stalling EX this cycle.
- ex_beq  in  1  EX instruction is BEQ.
- ex_bne  in  1  EX instruction is BNE.
- ex_jump  in  1  EX instruction is J/JAL.
- ex_zero  in  1  ALU zero flag for the EX instruction.
- ex_br_target  in  WIDTH  branch target from the EX adder (PC+4 + shifted offset).
- ex_j_target  in  WIDTH  jump target.
- redir_ready  in  1  fetch accepts the redirect this cycle.
- redir_valid  out  1  redirect request pending.
- redir_pc  out  WIDTH  new PC, stable while redir_valid=1.
- flush_ifid  out  1  clear the IF/ID register this cycle.
- flush_idex  out  1  clear the ID/EX register this cycle.
- busy  out  1  state is not IDLE.
- taken_count  out  COUNT_W  number of taken redirects since reset.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; redir_valid=0, redir_pc=0, flush_ifid=0, flush_idex=0, busy=0, taken_count=0. Reset asserted in any state aborts a pending redirect, with no partial output.
- Evaluation happens only when state=IDLE, ex_valid=1 and stall_in=0. In any other case the ex_* inputs are ignored.
- Taken condition, with priority ex_jump > ex_beq > ex_bne:
  - ex_jump=1 -> taken, target ex_j_target.
  - else ex_beq=1 -> taken iff ex_zero=1, target ex_br_target.
  - else ex_bne=1 -> taken iff ex_zero=0, target ex_br_target.
  - else not taken.
- All outputs are registered. A decision in cycle N appears on the outputs in cycle N+1.
- States:
  - IDLE:
    - Taken -> REDIRECT. redir_pc is loaded with the target; taken_count increments, saturating at all-ones.
    - Not taken -> stay in IDLE.
  - REDIRECT:
    - redir_valid=1, flush_ifid=1, flush_idex=1 every cycle.
    - redir_pc is held constant.
    - When redir_ready=1: if FLUSH_CYCLES>0, go to SQUASH with the counter loaded to FLUSH_CYCLES; if FLUSH_CYCLES=0, go to IDLE.
  - SQUASH:
    - redir_valid=0, flush_ifid=1, flush_idex=0.
    - The counter decrements each cycle; on reaching 1 (last squash cycle), go to IDLE.
- Handshake:
  - redir_valid never drops before redir_ready is seen.
  - redir_ready while redir_valid=0 is ignored.
  - The transfer occurs on the edge where both redir_valid and redir_ready are 1.
- flush outputs are 0 in IDLE. busy=1 in REDIRECT and SQUASH.
- redir_pc retains its last value after the handshake. Only redir_valid qualifies it.
- Target arithmetic: no modification; targets pass through at WIDTH bits with no alignment check.
- Back-to-back branches: the second branch cannot be evaluated until state returns to IDLE. Instructions behind the branch are squashed, so this is architecturally correct.
- Simultaneous stall_in=1 and a taken condition: no action that cycle. The decision is re-evaluated when stall_in drops.

Test Plan:
- BEQ taken: ex_valid=1, ex_beq=1, ex_zero=1, ex_br_target=0x0000_0040, redir_ready=1 tied high -> cycle N+1 shows redir_valid=1, redir_pc=0x40 and both flushes asserted. This is followed by 2 cycles of flush_ifid only, then IDLE; taken_count=1.
- BNE not taken: ex_bne=1, ex_zero=1 -> all outputs stay 0, taken_count unchanged. Then BNE with ex_zero=0 and target 0x80 -> redirect to 0x80.
- Jump with delayed ready: ex_jump=1, ex_beq=1, ex_j_target=0x0000_1000, ex_br_target=0x20, redir_ready low for 3 cycles -> redir_valid and redir_pc=0x1000 are held for 4 cycles with flush_idex=1 throughout. The handshake completes on the 4th cycle. ex_* changes during the wait are ignored.
- Stall masking: taken BEQ with stall_in=1 for 2 cycles -> no redirect. When stall_in drops, redir_valid rises on the next cycle.
- Reset mid-operation: assert reset during REDIRECT -> the next cycle has all outputs 0 and busy=0. A later taken branch works normally.
- Saturation / FLUSH_CYCLES=0: COUNT_W=2, FLUSH_CYCLES=0, five taken jumps with redir_ready=1 -> taken_count reads 1, 2, 3, 3, 3. Each redirect returns to IDLE the cycle after the handshake, with no SQUASH cycles.
